// File: rtl/pcs_receive.sv
// Purpose: 1000BASE-X PCS receive: 8b/10b decode with running-disparity check plus receive FSM driving GMII RX.
// Latency: all outputs registered; a code-group presented before edge N is reflected after edge N.
// Backpressure: none; exactly one code-group is consumed on every GTX_CLK edge.
module pcs_receive (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic [9:0] rx_code_group,
  input  logic       sync_status,
  output logic [7:0] RXD,
  output logic       RX_DV,
  output logic       RX_ER,
  output logic       receiving
);

  typedef enum logic [2:0] {
    LINK_FAILED, WAIT_FOR_K, RX_K, IDLE_D, RECEIVE, END_T, TRR
  } state_t;

  state_t     state, state_nxt;
  logic       rd, rd_nxt;            // running disparity, 1 = positive
  logic [7:0] rxd_nxt;
  logic       dv_nxt, er_nxt, rcv_nxt;

  // sub-block split: abcdei in the upper six bits, fghj in the lower four
  logic [5:0] six;
  logic [3:0] four;
  assign six  = rx_code_group[9:4];
  assign four = rx_code_group[3:0];

  // 5b/6b lookup: value plus which RD column(s) the pattern belongs to
  logic [4:0] x5;
  logic       ok6_n, ok6_p;
  always_comb begin
    x5 = 5'd0; ok6_n = 1'b0; ok6_p = 1'b0;
    case (six)
      6'b100111: begin x5 = 5'd0;  ok6_n = 1'b1; end
      6'b011000: begin x5 = 5'd0;  ok6_p = 1'b1; end
      6'b011101: begin x5 = 5'd1;  ok6_n = 1'b1; end
      6'b100010: begin x5 = 5'd1;  ok6_p = 1'b1; end
      6'b101101: begin x5 = 5'd2;  ok6_n = 1'b1; end
      6'b010010: begin x5 = 5'd2;  ok6_p = 1'b1; end
      6'b110001: begin x5 = 5'd3;  ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b110101: begin x5 = 5'd4;  ok6_n = 1'b1; end
      6'b001010: begin x5 = 5'd4;  ok6_p = 1'b1; end
      6'b101001: begin x5 = 5'd5;  ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b011001: begin x5 = 5'd6;  ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b111000: begin x5 = 5'd7;  ok6_n = 1'b1; end
      6'b000111: begin x5 = 5'd7;  ok6_p = 1'b1; end
      6'b111001: begin x5 = 5'd8;  ok6_n = 1'b1; end
      6'b000110: begin x5 = 5'd8;  ok6_p = 1'b1; end
      6'b100101: begin x5 = 5'd9;  ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b010101: begin x5 = 5'd10; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b110100: begin x5 = 5'd11; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b001101: begin x5 = 5'd12; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b101100: begin x5 = 5'd13; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b011100: begin x5 = 5'd14; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b010111: begin x5 = 5'd15; ok6_n = 1'b1; end
      6'b101000: begin x5 = 5'd15; ok6_p = 1'b1; end
      6'b011011: begin x5 = 5'd16; ok6_n = 1'b1; end
      6'b100100: begin x5 = 5'd16; ok6_p = 1'b1; end
      6'b100011: begin x5 = 5'd17; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b010011: begin x5 = 5'd18; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b110010: begin x5 = 5'd19; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b001011: begin x5 = 5'd20; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b101010: begin x5 = 5'd21; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b011010: begin x5 = 5'd22; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b111010: begin x5 = 5'd23; ok6_n = 1'b1; end
      6'b000101: begin x5 = 5'd23; ok6_p = 1'b1; end
      6'b110011: begin x5 = 5'd24; ok6_n = 1'b1; end
      6'b001100: begin x5 = 5'd24; ok6_p = 1'b1; end
      6'b100110: begin x5 = 5'd25; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b010110: begin x5 = 5'd26; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b110110: begin x5 = 5'd27; ok6_n = 1'b1; end
      6'b001001: begin x5 = 5'd27; ok6_p = 1'b1; end
      6'b001110: begin x5 = 5'd28; ok6_n = 1'b1; ok6_p = 1'b1; end
      6'b101110: begin x5 = 5'd29; ok6_n = 1'b1; end
      6'b010001: begin x5 = 5'd29; ok6_p = 1'b1; end
      6'b011110: begin x5 = 5'd30; ok6_n = 1'b1; end
      6'b100001: begin x5 = 5'd30; ok6_p = 1'b1; end
      6'b101011: begin x5 = 5'd31; ok6_n = 1'b1; end
      6'b010100: begin x5 = 5'd31; ok6_p = 1'b1; end
      default:   begin x5 = 5'd0;  end
    endcase
  end

  // 3b/4b lookup against the disparity left by the 6b block; A7 flags the alternate x.7 form
  logic [2:0] y3;
  logic       ok4_n, ok4_p, is_a7;
  always_comb begin
    y3 = 3'd0; ok4_n = 1'b0; ok4_p = 1'b0; is_a7 = 1'b0;
    case (four)
      4'b1011: begin y3 = 3'd0; ok4_n = 1'b1; end
      4'b0100: begin y3 = 3'd0; ok4_p = 1'b1; end
      4'b1001: begin y3 = 3'd1; ok4_n = 1'b1; ok4_p = 1'b1; end
      4'b0101: begin y3 = 3'd2; ok4_n = 1'b1; ok4_p = 1'b1; end
      4'b1100: begin y3 = 3'd3; ok4_n = 1'b1; end
      4'b0011: begin y3 = 3'd3; ok4_p = 1'b1; end
      4'b1101: begin y3 = 3'd4; ok4_n = 1'b1; end
      4'b0010: begin y3 = 3'd4; ok4_p = 1'b1; end
      4'b1010: begin y3 = 3'd5; ok4_n = 1'b1; ok4_p = 1'b1; end
      4'b0110: begin y3 = 3'd6; ok4_n = 1'b1; ok4_p = 1'b1; end
      4'b1110: begin y3 = 3'd7; ok4_n = 1'b1; end
      4'b0001: begin y3 = 3'd7; ok4_p = 1'b1; end
      4'b0111: begin y3 = 3'd7; ok4_n = 1'b1; is_a7 = 1'b1; end
      4'b1000: begin y3 = 3'd7; ok4_p = 1'b1; is_a7 = 1'b1; end
      default: begin y3 = 3'd0; end
    endcase
  end

  // disparity bookkeeping and validity of the group as a data octet
  logic [2:0] ones6, ones4;
  logic [3:0] ones10;
  logic       rd_mid, rd_end, a7_needed, d_valid;
  logic [7:0] d_octet;
  assign ones6     = 3'($countones(six));
  assign ones4     = 3'($countones(four));
  assign ones10    = 4'($countones(rx_code_group));
  assign rd_mid    = (ones6 == 3'd4) ? 1'b1 : (ones6 == 3'd2) ? 1'b0 : rd;
  assign rd_end    = (ones4 == 3'd3) ? 1'b1 : (ones4 == 3'd1) ? 1'b0 : rd_mid;
  assign a7_needed = rd_mid ? (x5 == 5'd11 || x5 == 5'd13 || x5 == 5'd14)
                            : (x5 == 5'd17 || x5 == 5'd18 || x5 == 5'd20);
  assign d_valid   = (rd ? ok6_p : ok6_n) && (rd_mid ? ok4_p : ok4_n) &&
                     ((y3 != 3'd7) || (is_a7 == a7_needed));
  assign d_octet   = {y3, x5};

  // every K group's RD+ form is the complement of its RD- form, so fold to RD- and compare
  logic [9:0] code_n;
  logic       is_k28_5, is_s, is_t, is_r, is_v, is_k_other, k_valid, grp_valid, rd_after;
  assign code_n     = rd ? ~rx_code_group : rx_code_group;
  assign is_k28_5   = (code_n == 10'h0FA);
  assign is_s       = (code_n == 10'h368);
  assign is_t       = (code_n == 10'h2E8);
  assign is_r       = (code_n == 10'h3A8);
  assign is_v       = (code_n == 10'h1E8);
  assign is_k_other = (code_n == 10'h0F4) || (code_n == 10'h0F9) || (code_n == 10'h0F5) ||
                      (code_n == 10'h0F3) || (code_n == 10'h0F2) || (code_n == 10'h0F6) ||
                      (code_n == 10'h0F8);
  assign k_valid    = is_k28_5 | is_s | is_t | is_r | is_v | is_k_other;
  assign grp_valid  = k_valid | d_valid;
  // an invalid group re-seeds RD from its own bit balance
  assign rd_after   = grp_valid ? rd_end : (ones10 > 4'd5);

  // next-state and registered-output selection from the current group and state
  always_comb begin
    state_nxt = state;
    rxd_nxt   = 8'h00;
    dv_nxt    = 1'b0;
    er_nxt    = 1'b0;
    rcv_nxt   = 1'b0;
    rd_nxt    = (state == LINK_FAILED) ? 1'b0 : rd_after;
    if (!sync_status) begin
      state_nxt = LINK_FAILED;
      rd_nxt    = 1'b0;
      er_nxt    = (state == RECEIVE);
    end else begin
      case (state)
        LINK_FAILED: state_nxt = WAIT_FOR_K;
        WAIT_FOR_K:  if (is_k28_5) state_nxt = RX_K;
        RX_K: begin
          if (d_valid && (d_octet == 8'h50 || d_octet == 8'hC5)) state_nxt = IDLE_D;
          else                                                  state_nxt = WAIT_FOR_K;
        end
        IDLE_D: begin
          if (is_k28_5) state_nxt = RX_K;
          else if (is_s) begin
            state_nxt = RECEIVE;
            rxd_nxt   = 8'h55;
            dv_nxt    = 1'b1;
            rcv_nxt   = 1'b1;
          end else state_nxt = WAIT_FOR_K;
        end
        RECEIVE: begin
          if (d_valid) begin
            rxd_nxt = d_octet;
            dv_nxt  = 1'b1;
            rcv_nxt = 1'b1;
          end else if (is_t) begin
            state_nxt = END_T;
            rcv_nxt   = 1'b1;
          end else if (is_k28_5) begin
            state_nxt = RX_K;
            er_nxt    = 1'b1;
          end else begin
            dv_nxt  = 1'b1;
            er_nxt  = 1'b1;
            rcv_nxt = 1'b1;
          end
        end
        END_T: begin
          if (is_r) state_nxt = TRR;
          else begin
            state_nxt = WAIT_FOR_K;
            er_nxt    = 1'b1;
          end
        end
        TRR: begin
          if (is_r)          state_nxt = TRR;
          else if (is_k28_5) state_nxt = RX_K;
          else               state_nxt = WAIT_FOR_K;
        end
        default: state_nxt = LINK_FAILED;
      endcase
    end
  end

  // state, disparity and GMII outputs; reset silences everything including RX_ER
  always_ff @(posedge GTX_CLK) begin
    if (!mr_main_reset) begin
      state     <= LINK_FAILED;
      rd        <= 1'b0;
      RXD       <= 8'h00;
      RX_DV     <= 1'b0;
      RX_ER     <= 1'b0;
      receiving <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd        <= rd_nxt;
      RXD       <= rxd_nxt;
      RX_DV     <= dv_nxt;
      RX_ER     <= er_nxt;
      receiving <= rcv_nxt;
    end
  end

endmodule

// File: tb/tb_pcs_receive.sv
// Purpose: directed code-group streams into pcs_receive with a per-group expected GMII response.
// Latency: response to each group is checked on the negedge after the edge that consumes it.
// Backpressure: none; the driver issues one group per cycle, the monitor retires one per cycle.
module tb_pcs_receive;

  logic       GTX_CLK = 1'b0;
  logic       mr_main_reset;
  logic [9:0] rx_code_group;
  logic       sync_status;
  logic [7:0] RXD;
  logic       RX_DV, RX_ER, receiving;

  pcs_receive dut (
    .GTX_CLK       (GTX_CLK),
    .mr_main_reset (mr_main_reset),
    .rx_code_group (rx_code_group),
    .sync_status   (sync_status),
    .RXD           (RXD),
    .RX_DV         (RX_DV),
    .RX_ER         (RX_ER),
    .receiving     (receiving)
  );

  always #5 GTX_CLK = ~GTX_CLK;

  // hand-encoded groups; suffix gives the running disparity they are valid in
  localparam logic [9:0] K28_5N = 10'h0FA, K28_5P = 10'h305;
  localparam logic [9:0] D16_2P = 10'h245, D5_6   = 10'h296;
  localparam logic [9:0] S_N    = 10'h368, T_N    = 10'h2E8, T_P = 10'h117;
  localparam logic [9:0] R_N    = 10'h3A8, R_P    = 10'h057, V_N = 10'h1E8;
  localparam logic [9:0] D1_0N  = 10'h1D4, D2_0N  = 10'h2D4;
  localparam logic [9:0] D3_0N  = 10'h31B, D3_2P  = 10'h315, D0_0BAD = 10'h18B;

  typedef struct packed {
    logic [7:0] rxd;
    logic       dv;
    logic       er;
    logic       rcv;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_pushed = 0;

  task automatic step(input logic rst, input logic sync, input logic [9:0] grp,
                      input logic [7:0] rxd, input logic dv, input logic er,
                      input logic rcv, input string nm);
    exp_t e;
    @(negedge GTX_CLK);
    mr_main_reset = rst;
    sync_status   = sync;
    rx_code_group = grp;
    e.rxd = rxd; e.dv = dv; e.er = er; e.rcv = rcv;
    exp_q.push_back(e);
    name_q.push_back(nm);
    n_pushed++;
  endtask

  task automatic idle(input logic [9:0] grp, input string nm);
    step(1'b1, 1'b1, grp, 8'h00, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic dat(input logic [9:0] grp, input logic [7:0] v, input string nm);
    step(1'b1, 1'b1, grp, v, 1'b1, 1'b0, 1'b1, nm);
  endtask

  task automatic bad(input logic [9:0] grp, input string nm);
    step(1'b1, 1'b1, grp, 8'h00, 1'b1, 1'b1, 1'b1, nm);
  endtask

  // monitor: an expectation queued before an edge is retired against the outputs after it
  initial begin
    exp_t  e, act;
    string nm;
    forever begin
      @(posedge GTX_CLK);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        @(negedge GTX_CLK);
        act = {RXD, RX_DV, RX_ER, receiving};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got RXD=%02h DV=%b ER=%b rcv=%b, want RXD=%02h DV=%b ER=%b rcv=%b",
                   nm, act.rxd, act.dv, act.er, act.rcv, e.rxd, e.dv, e.er, e.rcv);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc;
    mr_main_reset = 1'b0;
    sync_status   = 1'b0;
    rx_code_group = 10'h000;

    // reset, link failed, then idle acquisition
    step(1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, "reset0");
    step(1'b0, 1'b0, S_N,     8'h00, 1'b0, 1'b0, 1'b0, "reset1");
    step(1'b1, 1'b0, K28_5N,  8'h00, 1'b0, 1'b0, 1'b0, "lf_nosync");
    idle(K28_5N, "lf_exit");
    idle(K28_5N, "idle_k");  idle(D16_2P, "idle_d");
    idle(K28_5N, "idle_k2"); idle(D16_2P, "idle_d2");

    // clean frame ending in RD+, re-idled with /I1/
    dat(S_N, 8'h55, "a_sop");  dat(D1_0N, 8'h01, "a_d1"); dat(D2_0N, 8'h02, "a_d2");
    dat(D3_0N, 8'h03, "a_d3"); dat(D3_2P, 8'h43, "a_d4");
    step(1'b1, 1'b1, T_P, 8'h00, 1'b0, 1'b0, 1'b1, "a_t");
    idle(R_P, "a_r"); idle(K28_5P, "a_k"); idle(D5_6, "a_i1");

    // /V/ mid-frame
    dat(S_N, 8'h55, "b_sop"); dat(D1_0N, 8'h01, "b_d1"); bad(V_N, "b_v");
    dat(D2_0N, 8'h02, "b_d2");
    step(1'b1, 1'b1, T_N, 8'h00, 1'b0, 1'b0, 1'b1, "b_t");
    idle(R_N, "b_r"); idle(K28_5N, "b_k"); idle(D16_2P, "b_i2");

    // wrong-column data group, then /T/ without /R/
    dat(S_N, 8'h55, "c_sop"); bad(D0_0BAD, "c_bad_rd"); dat(D1_0N, 8'h01, "c_d1");
    step(1'b1, 1'b1, T_N,    8'h00, 1'b0, 1'b0, 1'b1, "c_t");
    step(1'b1, 1'b1, K28_5N, 8'h00, 1'b0, 1'b1, 1'b0, "c_t_no_r");
    idle(D16_2P, "c_wait"); idle(S_N, "c_sop_ignored");
    idle(K28_5N, "c_k"); idle(D16_2P, "c_i2");

    // early end: K28.5 straight after data lands in RX_K
    dat(S_N, 8'h55, "d_sop"); dat(D2_0N, 8'h02, "d_d2");
    step(1'b1, 1'b1, K28_5N, 8'h00, 1'b0, 1'b1, 1'b0, "d_early_k");
    idle(D16_2P, "d_i2"); dat(S_N, 8'h55, "d_sop2");
    step(1'b1, 1'b1, T_N, 8'h00, 1'b0, 1'b0, 1'b1, "d_t");
    idle(R_N, "d_r"); idle(K28_5N, "d_k"); idle(D16_2P, "d_i2b");

    // sync loss mid-frame, then re-acquisition
    dat(S_N, 8'h55, "e_sop"); dat(D3_0N, 8'h03, "e_d3");
    step(1'b1, 1'b0, D3_2P, 8'h00, 1'b0, 1'b1, 1'b0, "e_sync_drop");
    step(1'b1, 1'b0, S_N,   8'h00, 1'b0, 1'b0, 1'b0, "e_lf");
    idle(K28_5N, "e_lf_exit"); idle(K28_5N, "e_k"); idle(D16_2P, "e_i2");

    // data while in IDLE_D drops back to WAIT_FOR_K
    idle(D1_0N, "i_data_in_idle"); idle(S_N, "i_sop_ignored");
    idle(K28_5N, "i_k"); idle(D16_2P, "i_i2");

    // reset mid-frame, then a full recovery frame ending with repeated /R/
    dat(S_N, 8'h55, "f_sop"); dat(D1_0N, 8'h01, "f_d1");
    step(1'b0, 1'b1, D2_0N, 8'h00, 1'b0, 1'b0, 1'b0, "f_reset");
    idle(K28_5N, "f_lf"); idle(K28_5N, "f_k"); idle(D16_2P, "f_i2");
    dat(S_N, 8'h55, "f_sop2"); dat(D1_0N, 8'h01, "f_d1b");
    step(1'b1, 1'b1, T_N, 8'h00, 1'b0, 1'b0, 1'b1, "f_t");
    idle(R_N, "f_r1"); idle(R_N, "f_r2"); idle(K28_5N, "f_k2"); idle(D16_2P, "f_i2b");

    wait_cyc = 0;
    while (n_checks < n_pushed && wait_cyc < 50) begin
      @(posedge GTX_CLK);
      wait_cyc++;
    end
    #2;
    if (n_checks < n_pushed) begin
      n_fail++;
      $display("FAIL drain: %0d responses checked, %0d expected", n_checks, n_pushed);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
